// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the in-order pipeline. Owns the PC, drives a
// hold-until-data_ok instruction request, and hands one fetch packet per cycle
// to decode. A single skid entry absorbs the response that lands while decode
// is stalled. Redirects squash the current path, and the response to any
// request that was already on the bus is discarded when it arrives.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  // instruction bus
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  // pipeline control
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  // fetch packet to decode
  output logic        out_valid,
  output logic [31:0] out_raw_instr,
  output logic [63:0] out_pc
);

  // BUSY : a request is on the bus and its response will be kept.
  // FULL : output and skid both hold packets; the bus is idle.
  // FLUSH: a request from a squashed path is on the bus; its response is dropped.
  typedef enum logic [1:0] {
    ST_BUSY  = 2'd0,
    ST_FULL  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e      r_state;
  logic [63:0] r_pc;          // next address to request
  logic [63:0] r_req_addr;    // address of the request on the bus

  // output packet register O
  logic        r_out_valid;
  logic [63:0] r_out_pc;
  logic [31:0] r_out_instr;

  // skid register S; it holds a packet exactly when r_state == ST_FULL
  logic [63:0] r_skid_pc;
  logic [31:0] r_skid_instr;

  logic        w_fire;            // decode consumes O this cycle
  logic        w_out_free;        // O can take a new packet at this edge
  logic        w_take_skid;       // a kept response must park in S
  logic [63:0] w_redirect_target; // redirect address, word aligned
  logic [63:0] w_req_next;        // sequential successor of the bus address

  assign w_fire            = r_out_valid & ~stall;
  assign w_out_free        = ~r_out_valid | w_fire;
  assign w_redirect_target = {redirect_pc[63:2], 2'b00};
  // 64-bit add: the successor of 64'hFFFF_FFFF_FFFF_FFFC wraps to 0
  assign w_req_next        = r_req_addr + 64'd4;
  assign w_take_skid       = (r_state == ST_BUSY) & iresp_data_ok & ~w_out_free
                           & ~redirect_valid;

  // NOTE: reset gates the valids combinationally so that neither the bus nor
  // decode sees a valid during the reset cycle itself; the registers clear at
  // the same edge, so the gating only matters for that one cycle.
  assign ireq_valid    = ~reset & (r_state != ST_FULL);
  assign ireq_addr     = r_req_addr;
  assign out_valid     = r_out_valid & ~reset;
  assign out_pc        = r_out_pc;
  assign out_raw_instr = r_out_instr;

  // Fetch control FSM: PC, bus address and output packet; redirect outranks all.
  // NOTE: every register here is written with <= so all branches see the
  // pre-edge values of r_state, r_pc and the output packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_BUSY;
      r_pc        <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_pc    <= 64'd0;
      r_out_instr <= 32'd0;
    end else if (redirect_valid) begin
      // The packet in O and anything in S belong to the squashed path.
      r_out_valid <= 1'b0;
      r_pc        <= w_redirect_target;
      case (r_state)
        ST_BUSY: begin
          if (iresp_data_ok) begin
            // response of the old path arrives now: drop it and reissue
            r_req_addr <= w_redirect_target;
          end else begin
            // old request still in flight: wait for it and discard it
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (iresp_data_ok) begin
            r_req_addr <= w_redirect_target;
            r_state    <= ST_BUSY;
          end
        end
        default: begin
          // FULL: bus idle, so the new path can be requested at once
          r_req_addr <= w_redirect_target;
          r_state    <= ST_BUSY;
        end
      endcase
    end else begin
      case (r_state)
        ST_BUSY: begin
          if (iresp_data_ok) begin
            if (w_out_free) begin
              r_out_valid <= 1'b1;
              r_out_pc    <= r_req_addr;
              r_out_instr <= iresp_data;
              r_req_addr  <= w_req_next;
            end else begin
              // O is blocked: response parks in S and the bus goes idle
              r_state <= ST_FULL;
            end
            r_pc <= w_req_next;
          end else if (w_fire) begin
            r_out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_skid_pc;
            r_out_instr <= r_skid_instr;
            r_req_addr  <= r_pc;
            r_state     <= ST_BUSY;
          end
        end
        default: begin
          // FLUSH: O was cleared by the redirect; retire the stale response
          if (w_fire) begin
            r_out_valid <= 1'b0;
          end
          if (iresp_data_ok) begin
            r_req_addr <= r_pc;
            r_state    <= ST_BUSY;
          end
        end
      endcase
    end
  end

  // Skid payload capture when a kept response meets a blocked output packet.
  // NOTE: the skid payload has no reset; its contents are only meaningful in
  // ST_FULL, and that state is reachable only through this load.
  always_ff @(posedge clk) begin
    if (!reset && w_take_skid) begin
      r_skid_pc    <= r_req_addr;
      r_skid_instr <= iresp_data;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Randomized bench for fetch_stage. A memory/bus model answers requests after a
// random latency. The reference model tracks the fetch path as a stream: the PC
// decode should see next and how many fetched-but-undelivered words exist.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_raw_instr;
  logic [63:0] out_pc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_raw_instr  (out_raw_instr),
    .out_pc         (out_pc)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, actual, expected);
    end
  endtask

  // instruction memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h0F1E_2D3C;
  endfunction

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    case ($urandom_range(0, 3))
      0:       t = 64'h8000_1000 + 64'($urandom_range(0, 63));
      1:       t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      2:       t = {$urandom, $urandom};
      default: t = RESET_PC + 64'($urandom_range(0, 31) * 4);
    endcase
    return t;
  endfunction

  // reference model: head PC of the path and words fetched but not consumed
  logic [63:0] m_ptr;
  int          m_buf;
  bit          m_stale;       // a squashed-path request is still on the bus
  bit          m_prev_reset;

  // bus model
  bit          b_pend;
  int          b_lat;
  int          b_wait;
  logic [63:0] b_addr;

  // knobs and one-shot forces
  int          k_min_lat, k_max_lat, k_stall_pct, k_redir_pct, k_reset_pm;
  int          f_stall;
  bit          f_redirect;
  bit          f_reset;
  logic [63:0] f_target;

  // values seen by the DUT's input side during the current cycle
  logic        s_ireq_valid;
  logic [63:0] s_ireq_addr;
  logic        s_out_valid;

  task automatic step();
    bit fire;
    bit acc;
    @(negedge clk);
    // registered outputs versus the stream model
    check("out_valid", 64'(out_valid), 64'(m_buf > 0));
    if (m_buf > 0) begin
      check("out_pc", out_pc, m_ptr);
      check("out_raw_instr", 64'(out_raw_instr), 64'(mem_word(m_ptr)));
    end
    if (m_buf == 2) check("no_req_while_skid_full", 64'(ireq_valid), 64'd0);

    reset   = f_reset || ($urandom_range(0, 999) < k_reset_pm);
    f_reset = 1'b0;
    #1;
    if (reset) begin
      check("reset_ireq_valid", 64'(ireq_valid), 64'd0);
      check("reset_out_valid", 64'(out_valid), 64'd0);
    end else if (m_prev_reset) begin
      check("first_req_valid", 64'(ireq_valid), 64'd1);
      check("first_req_addr", ireq_addr, RESET_PC);
    end

    // memory answers after a per-request random latency
    iresp_data_ok = 1'b0;
    iresp_data    = $urandom;
    if (!reset && ireq_valid) begin
      if (!b_pend) begin
        b_pend = 1'b1;
        b_lat  = $urandom_range(k_min_lat, k_max_lat);
        b_wait = 0;
        b_addr = ireq_addr;
      end else begin
        check("ireq_addr_stable", ireq_addr, b_addr);
      end
      if (b_wait >= b_lat) begin
        iresp_data_ok = 1'b1;
        iresp_data    = mem_word(ireq_addr);
      end
    end

    stall = (f_stall > 0) || ($urandom_range(0, 99) < k_stall_pct);
    if (f_stall > 0) f_stall--;
    redirect_valid = f_redirect || ($urandom_range(0, 99) < k_redir_pct);
    redirect_pc    = f_redirect ? f_target : rand_target();
    f_redirect     = 1'b0;

    s_ireq_valid = ireq_valid;
    s_ireq_addr  = ireq_addr;
    s_out_valid  = out_valid;

    @(posedge clk);
    if (reset) begin
      m_ptr   = RESET_PC;
      m_buf   = 0;
      m_stale = 1'b0;
      b_pend  = 1'b0;
    end else begin
      if (iresp_data_ok) b_pend = 1'b0;
      else if (b_pend)   b_wait++;
      if (redirect_valid) begin
        m_ptr   = {redirect_pc[63:2], 2'b00};
        m_buf   = 0;
        m_stale = s_ireq_valid && !iresp_data_ok;
      end else begin
        fire = s_out_valid && !stall;
        acc  = iresp_data_ok && !m_stale;
        if (iresp_data_ok && m_stale) m_stale = 1'b0;
        // a kept response must be the next word the path still lacks
        if (acc) check("fetch_addr", s_ireq_addr, m_ptr + 64'(4 * m_buf));
        if (fire) m_ptr = m_ptr + 64'd4;
        m_buf = m_buf + int'(acc) - int'(fire);
      end
    end
    m_prev_reset = reset;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_knobs(input int min_lat, input int max_lat, input int stall_pct,
                           input int redir_pct, input int reset_pm);
    k_min_lat   = min_lat;
    k_max_lat   = max_lat;
    k_stall_pct = stall_pct;
    k_redir_pct = redir_pct;
    k_reset_pm  = reset_pm;
  endtask

  task automatic force_redirect(input logic [63:0] target);
    f_redirect = 1'b1;
    f_target   = target;
  endtask

  initial begin
    reset          = 1'b1;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'd0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    f_stall        = 0;
    f_redirect     = 1'b0;
    f_reset        = 1'b0;
    f_target       = 64'd0;
    b_pend         = 1'b0;
    b_lat          = 0;
    b_wait         = 0;
    b_addr         = 64'd0;
    m_ptr          = RESET_PC;
    m_buf          = 0;
    m_stale        = 1'b0;
    m_prev_reset   = 1'b1;
    set_knobs(0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_pc", out_pc, 64'd0);
    check("reset_out_raw_instr", 64'(out_raw_instr), 64'd0);
    check("reset_hold_out_valid", 64'(out_valid), 64'd0);
    check("reset_hold_ireq_valid", 64'(ireq_valid), 64'd0);

    // streaming: response in the request cycle, no stall
    run(6);

    // decode stalls three cycles: S fills, bus idles, nothing lost
    f_stall = 3;
    run(8);

    // redirect to a misaligned target while a slow request is in flight
    set_knobs(2, 2, 0, 0, 0);
    run(3);
    force_redirect(64'h8000_1002);
    run(10);

    // redirect in the same cycle as a response
    set_knobs(0, 0, 0, 0, 0);
    run(2);
    force_redirect(64'h8000_2000);
    run(4);

    // redirect while O and S are both full
    f_stall = 4;
    run(3);
    force_redirect(64'h8000_3000);
    run(6);

    // PC wrap at the top of the address space
    force_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    run(6);

    // one-cycle reset in the middle of a request
    set_knobs(2, 2, 0, 0, 0);
    run(2);
    f_reset = 1'b1;
    run(8);

    // randomized traffic with periodically changing knobs
    for (int blk = 0; blk < 20; blk++) begin
      int lo;
      lo = $urandom_range(0, 1);
      set_knobs(lo, $urandom_range(lo, 3), $urandom_range(0, 60),
                $urandom_range(0, 10), $urandom_range(0, 5));
      run(200);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
